// File: rtl/pwm3_schematic_if.sv
// Board-level switch inputs and PWM output of the 3-bit modulator.
// master = stimulus side (switches), slave = the modulator.
interface pwm3_schematic_if;
  logic INPUT_1;
  logic INPUT_2;
  logic INPUT_3;
  logic INPUT_4;
  logic OUTPUT_1;

  modport master (
    output INPUT_1,
    output INPUT_2,
    output INPUT_3,
    output INPUT_4,
    input  OUTPUT_1
  );

  modport slave (
    input  INPUT_1,
    input  INPUT_2,
    input  INPUT_3,
    input  INPUT_4,
    output OUTPUT_1
  );
endinterface

// File: rtl/pwm3_schematic.sv
// 3-bit PWM: free-running period counter compared against a duty word
// that is latched at the start of each period; output is registered.
module pwm3_schematic #(
  parameter int WIDTH = 3
) (
  input logic               Clock,
  input logic               CLR,
  pwm3_schematic_if.slave   bus
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] duty_q;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] d_eff;
  logic             out_q;

  // Duty word assembled from the switch inputs, LSB on INPUT_1.
  always_comb begin
    din   = WIDTH'({bus.INPUT_3, bus.INPUT_2, bus.INPUT_1});
    d_eff = (cnt == '0) ? din : duty_q;
  end

  // Counter, duty latch and registered compare; disable holds the period.
  always_ff @(posedge Clock or posedge CLR) begin
    if (CLR) begin
      cnt    <= '0;
      duty_q <= '0;
      out_q  <= 1'b0;
    end else if (bus.INPUT_4) begin
      out_q <= (d_eff > cnt);
      if (cnt == '0)
        duty_q <= din;
      cnt <= cnt + 1'b1;
    end else begin
      out_q <= 1'b0;
    end
  end

  assign bus.OUTPUT_1 = out_q;

endmodule

// File: tb/tb_pwm3_schematic.sv
// Directed bench for pwm3_schematic: hand-computed per-edge output
// patterns for several duty values, enable hold and async reset.
module tb_pwm3_schematic;

  logic Clock;
  logic CLR;
  int   checks;
  int   errors;

  pwm3_schematic_if bus ();

  pwm3_schematic #(.WIDTH(3)) dut (
    .Clock (Clock),
    .CLR   (CLR),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #10 Clock = ~Clock;

  task automatic check(input string tag, input logic exp);
    checks++;
    assert (bus.OUTPUT_1 === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, bus.OUTPUT_1, exp);
    end
  endtask

  task automatic set_din(input int d);
    bus.INPUT_1 = d[0];
    bus.INPUT_2 = d[1];
    bus.INPUT_3 = d[2];
  endtask

  // Advance one rising edge, then sample at the following falling edge.
  task automatic step(input string tag, input logic exp);
    @(posedge Clock);
    @(negedge Clock);
    check(tag, exp);
  endtask

  // Run n edges expecting the bit pattern pat (bit 7 first, repeating).
  task automatic run_pat(input string tag, input logic [7:0] pat,
                         input int n);
    for (int i = 0; i < n; i++)
      step(tag, pat[7 - (i % 8)]);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    CLR = 1'b1;
    set_din(7);
    bus.INPUT_4 = 1'b1;

    // Reset held for two edges.
    #1;
    check("reset_async", 1'b0);
    step("reset_e1", 1'b0);
    step("reset_e2", 1'b0);
    CLR = 1'b0;

    // DIN=7: 7 high, 1 low; high on the first edge after release.
    run_pat("d7", 8'b1111_1110, 16);

    // DIN=0: constantly low.
    set_din(0);
    run_pat("d0", 8'b0000_0000, 32);

    // DIN=3 then DIN=4.
    set_din(3);
    run_pat("d3", 8'b1110_0000, 16);
    set_din(4);
    run_pat("d4", 8'b1111_0000, 16);

    // DIN=2, change to 5 at cnt=4: takes effect next period.
    set_din(2);
    run_pat("d2_cur", 8'b1100_0000, 4);
    set_din(5);
    step("d2_tail4", 1'b0);
    step("d2_tail5", 1'b0);
    step("d2_tail6", 1'b0);
    step("d2_tail7", 1'b0);
    run_pat("d5_next", 8'b1111_1000, 8);

    // DIN=7, disable at cnt=5 for 3 edges; cnt must hold.
    set_din(7);
    run_pat("en_pre", 8'b1111_1000, 5);
    bus.INPUT_4 = 1'b0;
    set_din(0);
    step("en_off1", 1'b0);
    step("en_off2", 1'b0);
    step("en_off3", 1'b0);
    bus.INPUT_4 = 1'b1;
    set_din(7);
    step("en_res5", 1'b1);
    step("en_res6", 1'b1);
    step("en_res7", 1'b0);
    run_pat("en_next", 8'b1111_1110, 8);

    // Async reset mid-period with DIN=7.
    run_pat("clr_pre", 8'b1110_0000, 3);
    #5;
    CLR = 1'b1;
    #1;
    check("clr_async", 1'b0);
    step("clr_hold1", 1'b0);
    step("clr_hold2", 1'b0);
    CLR = 1'b0;
    run_pat("clr_post", 8'b1111_1110, 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
